// File: rtl/rr_seq_pkg.sv
// Shared types and constants for the register-register execute sequencer.
// Holds the FSM state encoding, the legal ALU opcode window, the HI/LO opcodes and the err codes.
// Nothing here is clocked.
package rr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    // Plain ALU ops occupy one contiguous window: ADD is the low edge.
    localparam logic [4:0] OP_ADD     = 5'b00011;
    localparam logic [4:0] OP_SUB     = 5'b00100;
    localparam logic [4:0] OP_ALU_MIN = OP_ADD;
    localparam logic [4:0] OP_ALU_MAX = 5'b01110;
    localparam logic [4:0] OP_MUL     = 5'b01111;
    localparam logic [4:0] OP_DIV     = 5'b10000;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // MUL/DIV write a double-width result through HI/LO instead of a general register.
    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic opcode_legal(input logic [4:0] op, input logic hilo_en);
        return ((op >= OP_ALU_MIN) && (op <= OP_ALU_MAX)) || (hilo_en && is_hilo_op(op));
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Purpose: register index plus enable to a one-hot register select vector.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs directly.
// Ports: i_idx register index, i_en select enable, o_onehot one-hot select (all zero when disabled).
module reg_sel_decoder #(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic [REG_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_exec_sequencer.sv
// Purpose: fetch/execute control sequencer for three-register ALU instructions (op Ra,Rb,Rc).
// Latency: start edge to done is 7 cycles with memory ready (8 on the HI/LO path), plus any T1 wait.
// Backpressure: stalls in T1 until mem_ready, aborting after MEM_TIMEOUT wait cycles; start ignored while busy.
// Optional build macro RR_SEQ_HILO_EN: makes MUL/DIV legal and adds the T6 HI/LO write-back step.
// Ports: clk/clr (sync active-high reset); start, mem_ready, ir_word in; busy, done, err status out;
//        fetch controls (PC_out..IR_enable), execute controls (Y_enable..LO_enable), opcode, R_out, R_enable.
module rr_exec_sequencer
    import rr_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   ir_word,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic                PC_out,
    output logic                MAR_enable,
    output logic                IncPC,
    output logic                PC_enable,
    output logic                Read,
    output logic                MDR_enable,
    output logic                MDR_out,
    output logic                IR_enable,
    output logic                Y_enable,
    output logic                Z_enable,
    output logic                ZLow_out,
    output logic                ZHigh_out,
    output logic                HI_enable,
    output logic                LO_enable,
    output logic [OPCODE_W-1:0] opcode,
    output logic [NUM_REGS-1:0] R_out,
    output logic [NUM_REGS-1:0] R_enable
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

`ifdef RR_SEQ_HILO_EN
    localparam logic HILO_EN = 1'b1;
`else
    localparam logic HILO_EN = 1'b0;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_nxt;
    logic               r_done;
    logic [1:0]         r_err;
    logic               w_done_nxt;
    logic [1:0]         w_err_nxt;

    logic [OPCODE_W-1:0] w_op;
    logic [REG_W-1:0]    w_ra;
    logic [REG_W-1:0]    w_rb;
    logic [REG_W-1:0]    w_rc;
    logic                w_legal;
    logic [REG_W-1:0]    w_rout_idx;
    logic                w_rout_en;
    logic                w_ren_en;
    logic                w_unused_ir;

    // Instruction fields: opcode at the top, then Ra, Rb, Rc packed downwards.
    assign w_op        = ir_word[DATA_W-1 -: OPCODE_W];
    assign w_ra        = ir_word[DATA_W-OPCODE_W-1 -: REG_W];
    assign w_rb        = ir_word[DATA_W-OPCODE_W-REG_W-1 -: REG_W];
    assign w_rc        = ir_word[DATA_W-OPCODE_W-2*REG_W-1 -: REG_W];
    assign w_unused_ir = ^ir_word[DATA_W-OPCODE_W-3*REG_W-1:0];
    assign w_legal     = opcode_legal(w_op, HILO_EN);

`ifdef RR_SEQ_HILO_EN
    logic w_is_hilo;
    assign w_is_hilo = is_hilo_op(w_op);
`endif

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign err  = r_err;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= ERR_OK;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wait_nxt = '0;
        w_done_nxt = 1'b0;
        w_err_nxt  = ERR_OK;
        PC_out     = 1'b0;
        MAR_enable = 1'b0;
        IncPC      = 1'b0;
        PC_enable  = 1'b0;
        Read       = 1'b0;
        MDR_enable = 1'b0;
        MDR_out    = 1'b0;
        IR_enable  = 1'b0;
        Y_enable   = 1'b0;
        Z_enable   = 1'b0;
        ZLow_out   = 1'b0;
        ZHigh_out  = 1'b0;
        HI_enable  = 1'b0;
        LO_enable  = 1'b0;
        opcode     = '0;
        w_rout_idx = w_rb;
        w_rout_en  = 1'b0;
        w_ren_en   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_T0;
            end
            S_T0: begin
                PC_out     = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                PC_enable  = 1'b1;
                w_next     = S_T1;
            end
            S_T1: begin
                Read       = 1'b1;
                MDR_enable = 1'b1;
                // Ready is checked first so data arriving on the last allowed cycle is accepted.
                if (mem_ready) begin
                    w_next = S_T2;
                end else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    w_next     = S_IDLE;
                    w_done_nxt = 1'b1;
                    w_err_nxt  = ERR_TIMEOUT;
                end else begin
                    w_wait_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_T2: begin
                MDR_out   = 1'b1;
                IR_enable = 1'b1;
                w_next    = S_T3;
            end
            S_T3: begin
                if (!w_legal) begin
                    w_next     = S_IDLE;
                    w_done_nxt = 1'b1;
                    w_err_nxt  = ERR_ILLEGAL;
                end else begin
                    w_rout_en = 1'b1;
                    Y_enable  = 1'b1;
                    w_next    = S_T4;
                end
            end
            S_T4: begin
                w_rout_idx = w_rc;
                w_rout_en  = 1'b1;
                opcode     = w_op;
                Z_enable   = 1'b1;
                w_next     = S_T5;
            end
            S_T5: begin
                ZLow_out = 1'b1;
`ifdef RR_SEQ_HILO_EN
                if (w_is_hilo) begin
                    LO_enable = 1'b1;
                    w_next    = S_T6;
                end else begin
                    w_ren_en   = 1'b1;
                    w_next     = S_IDLE;
                    w_done_nxt = 1'b1;
                end
`else
                w_ren_en   = 1'b1;
                w_next     = S_IDLE;
                w_done_nxt = 1'b1;
`endif
            end
`ifdef RR_SEQ_HILO_EN
            S_T6: begin
                ZHigh_out  = 1'b1;
                HI_enable  = 1'b1;
                w_next     = S_IDLE;
                w_done_nxt = 1'b1;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (R_out)
    );

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_ren_dec (
        .i_idx    (w_ra),
        .i_en     (w_ren_en),
        .o_onehot (R_enable)
    );

endmodule

// File: tb/tb_rr_exec_sequencer.sv
// Purpose: directed scoreboard bench for rr_exec_sequencer.
// Latency: expectation records are popped when the DUT pulses done.
// Backpressure: mem_ready is held low for a chosen number of T1 cycles per instruction.
module tb_rr_exec_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir_word;
    logic        busy, done;
    logic [1:0]  err;
    logic        PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable;
    logic        Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable, LO_enable;
    logic [4:0]  opcode;
    logic [15:0] R_out, R_enable;

    rr_exec_sequencer #(
        .DATA_W(32), .NUM_REGS(16), .OPCODE_W(5), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir_word(ir_word),
        .busy(busy), .done(done), .err(err),
        .PC_out(PC_out), .MAR_enable(MAR_enable), .IncPC(IncPC), .PC_enable(PC_enable),
        .Read(Read), .MDR_enable(MDR_enable), .MDR_out(MDR_out), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .Z_enable(Z_enable), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out),
        .HI_enable(HI_enable), .LO_enable(LO_enable), .opcode(opcode),
        .R_out(R_out), .R_enable(R_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [55:0] ctl_all;
    assign ctl_all = {busy, done, err, PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable,
                      MDR_out, IR_enable, Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable,
                      LO_enable, opcode, R_out, R_enable};

    typedef struct {
        logic [1:0]  err;
        int          lat;
        int          reads;
        int          irs;
        logic [15:0] y;
        logic [15:0] z;
        logic [4:0]  opc;
        logic [15:0] ren;
        int          ren_cnt;
        int          lo;
        int          hi;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] e, input int lat, input int reads, input int irs,
                                input logic [15:0] y, input logic [15:0] z, input logic [4:0] opc,
                                input logic [15:0] ren, input int ren_cnt, input int lo, input int hi);
        exp_t r;
        r.err = e; r.lat = lat; r.reads = reads; r.irs = irs; r.y = y; r.z = z; r.opc = opc;
        r.ren = ren; r.ren_cnt = ren_cnt; r.lo = lo; r.hi = hi;
        return r;
    endfunction

    // Per-instruction observations, gathered while busy and judged at done.
    int          o_busy, o_reads, o_irs, o_ren_cnt, o_lo, o_hi;
    logic [15:0] o_y, o_z, o_ren;
    logic [4:0]  o_opc;

    task automatic obs_clear();
        o_busy = 0; o_reads = 0; o_irs = 0; o_ren_cnt = 0; o_lo = 0; o_hi = 0;
        o_y = '0; o_z = '0; o_ren = '0; o_opc = '0;
    endtask

    initial obs_clear();

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = q.pop_front();
                // Latency counts the busy cycles plus the done cycle itself.
                chk("err",          64'(err),         64'(e.err));
                chk("latency",      64'(o_busy + 1),  64'(e.lat));
                chk("read_cycles",  64'(o_reads),     64'(e.reads));
                chk("ir_enable",    64'(o_irs),       64'(e.irs));
                chk("rout_T3",      64'(o_y),         64'(e.y));
                chk("rout_T4",      64'(o_z),         64'(e.z));
                chk("opcode_T4",    64'(o_opc),       64'(e.opc));
                chk("renable_mask", 64'(o_ren),       64'(e.ren));
                chk("renable_cnt",  64'(o_ren_cnt),   64'(e.ren_cnt));
                chk("lo_enable",    64'(o_lo),        64'(e.lo));
                chk("hi_enable",    64'(o_hi),        64'(e.hi));
            end
            obs_clear();
        end else if (!busy) begin
            chk("err_idle", 64'(err), 64'd0);
            obs_clear();
        end else begin
            o_busy++;
            if (Read) o_reads++;
            if (IR_enable) o_irs++;
            if (Y_enable) o_y = R_out;
            if (Z_enable) begin
                o_z   = R_out;
                o_opc = opcode;
            end
            o_ren = o_ren | R_enable;
            if (R_enable != 16'd0) o_ren_cnt++;
            if (LO_enable) o_lo++;
            if (HI_enable) o_hi++;
            chk("rout_onehot",   64'($countones(R_out) <= 1),    64'd1);
            chk("renable_onehot", 64'($countones(R_enable) <= 1), 64'd1);
            if (!Z_enable) chk("opcode_outside_T4", 64'(opcode), 64'd0);
        end
    end

    // Issue one instruction; mem_ready stays low for the first 'stall' T1 cycles.
    task automatic run(input logic [31:0] ir, input int stall, input int hold);
        int n;
        bit finished;
        n = 0;
        finished = 1'b0;
        @(negedge clk);
        ir_word   = ir;
        mem_ready = (stall == 0);
        start     = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (Read) begin
                n++;
                mem_ready = (n > stall);
            end
            @(negedge clk);
        end
        if (!finished) chk("run_bound", 64'(busy), 64'd0);
        mem_ready = 1'b1;
    endtask

    initial begin
        bit seen;
        clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir_word = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(ctl_all), 64'd0);
        clr = 1'b0;

        // SUB R0,R4,R5 with start held 3 cycles (extra start while busy is ignored).
        q.push_back(mk(2'b00, 7, 1, 1, 16'h0010, 16'h0020, 5'b00100, 16'h0001, 1, 0, 0));
        run(32'h20228000, 0, 3);

        // Same instruction, memory late by 3 cycles.
        q.push_back(mk(2'b00, 10, 4, 1, 16'h0010, 16'h0020, 5'b00100, 16'h0001, 1, 0, 0));
        run(32'h20228000, 3, 1);

        // Memory never ready: abort after 15 T1 cycles.
        q.push_back(mk(2'b10, 17, 15, 0, 16'h0, 16'h0, 5'd0, 16'h0, 0, 0, 0));
        run(32'h20228000, 1000, 1);

        // Ready on the last allowed T1 cycle: accepted.
        q.push_back(mk(2'b00, 21, 15, 1, 16'h0010, 16'h0020, 5'b00100, 16'h0001, 1, 0, 0));
        run(32'h20228000, 14, 1);

        // Opcode 11111 is illegal.
        q.push_back(mk(2'b01, 5, 1, 1, 16'h0, 16'h0, 5'd0, 16'h0, 0, 0, 0));
        run(32'hFFFF8000, 0, 1);

        // Opcode 00010, just below the legal window.
        q.push_back(mk(2'b01, 5, 1, 1, 16'h0, 16'h0, 5'd0, 16'h0, 0, 0, 0));
        run(32'h10000000, 0, 1);

        // Opcode 01110, top of the legal window, Ra=Rb=Rc=R9.
        q.push_back(mk(2'b00, 7, 1, 1, 16'h0200, 16'h0200, 5'b01110, 16'h0200, 1, 0, 0));
        run(32'h74CC8000, 0, 1);

        // MUL R2,R3,R4 and DIV R0,R0,R0.
`ifdef RR_SEQ_HILO_EN
        q.push_back(mk(2'b00, 8, 1, 1, 16'h0008, 16'h0010, 5'b01111, 16'h0, 0, 1, 1));
        run(32'h791A0000, 0, 1);
        q.push_back(mk(2'b00, 8, 1, 1, 16'h0001, 16'h0001, 5'b10000, 16'h0, 0, 1, 1));
        run(32'h80000000, 0, 1);
`else
        q.push_back(mk(2'b01, 5, 1, 1, 16'h0, 16'h0, 5'd0, 16'h0, 0, 0, 0));
        run(32'h791A0000, 0, 1);
        q.push_back(mk(2'b01, 5, 1, 1, 16'h0, 16'h0, 5'd0, 16'h0, 0, 0, 0));
        run(32'h80000000, 0, 1);
`endif

        // clr during T4 aborts with no done pulse.
        @(negedge clk);
        ir_word = 32'h20228000; mem_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (Z_enable) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_T4", 64'(seen), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_abort_outputs", 64'(ctl_all), 64'd0);
        clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("clr_no_done", 64'(done), 64'd0);
        end

        // ADD R7,R1,R15 after the abort runs clean.
        q.push_back(mk(2'b00, 7, 1, 1, 16'h0002, 16'h8000, 5'b00011, 16'h0080, 1, 0, 0));
        run(32'h1B8F8000, 0, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
